// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// Imported by the interface, the adder cell and the controller.
package serial_adder_ctrl_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic int cnt_w(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Start/done handshake and operand/result bundle of the serial adder.
// master = requester, slave = the adder controller.
interface serial_adder_ctrl_if
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             ready;
    logic             busy;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    logic             done;

    modport master (
        output start, a, b, cin,
        input  ready, busy, sum, cout, overflow, done
    );

    modport slave (
        input  start, a, b, cin,
        output ready, busy, sum, cout, overflow, done
    );

endinterface

// File: rtl/serial_adder_ctrl_full_adder_bit.sv
// Shared 1-bit full-adder cell: two half-adder stages plus an OR.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;
    logic g1;
    logic g2;

    assign p  = a ^ b;
    assign g1 = a & b;
    assign s  = p ^ ci;
    assign g2 = p & ci;
    assign co = g1 | g2;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands LSB-first
// through one shared full-adder cell, one bit per cycle.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input logic               clk,
    input logic               rst,
    serial_adder_ctrl_if.slave bus
);

    localparam int CW = cnt_w(WIDTH);

    state_t           state_q;
    state_t           state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             carry_q;
    logic             cmsb_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             done_q;
    logic             s;
    logic             cn;
    logic             last;

    full_adder_bit u_fa (
        .a  (a_q[0]),
        .b  (b_q[0]),
        .ci (carry_q),
        .s  (s),
        .co (cn)
    );

    assign last = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_ADD;
            S_ADD:   if (last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cmsb_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        carry_q <= bus.cin;
                        cnt_q   <= '0;
                    end
                end
                S_ADD: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    res_q   <= {s, res_q[WIDTH-1:1]};
                    carry_q <= cn;
                    // carry into the MSB is kept for the overflow flag
                    if (last) cmsb_q <= carry_q;
                    else      cnt_q  <= cnt_q + CW'(1);
                end
                S_DONE: begin
                    sum_q  <= res_q;
                    cout_q <= carry_q;
                    ovf_q  <= cmsb_q ^ carry_q;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.ready    = (state_q == S_IDLE);
    assign bus.busy     = (state_q == S_ADD) || (state_q == S_DONE);
    assign bus.sum      = sum_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: cycle-level reference model plus
// directed literal cases and randomized traffic.
module tb_serial_adder_ctrl;
    import serial_adder_ctrl_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    serial_adder_ctrl_if #(.WIDTH(W)) bus ();

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: cycles elapsed since acceptance, and plain arithmetic.
    int           phase = 0;
    logic [W-1:0] m_sum = '0;
    logic         m_cout = 1'b0;
    logic         m_ovf = 1'b0;
    logic         m_done = 1'b0;
    logic [W-1:0] p_sum;
    logic         p_cout;
    logic         p_ovf;
    logic [W:0]   m_t;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            phase  = 0;
            m_sum  = '0;
            m_cout = 1'b0;
            m_ovf  = 1'b0;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (phase == 0) begin
                if (bus.start) begin
                    m_t    = {1'b0, bus.a} + {1'b0, bus.b} + {{W{1'b0}}, bus.cin};
                    p_sum  = m_t[W-1:0];
                    p_cout = m_t[W];
                    p_ovf  = (bus.a[W-1] == bus.b[W-1]) && (m_t[W-1] != bus.a[W-1]);
                    phase  = 1;
                end
            end else begin
                phase++;
                if (phase == W + 2) begin
                    phase  = 0;
                    m_sum  = p_sum;
                    m_cout = p_cout;
                    m_ovf  = p_ovf;
                    m_done = 1'b1;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        checks++;
        if (bus.ready !== (phase == 0) || bus.busy !== (phase != 0) ||
            bus.done !== m_done || bus.sum !== m_sum ||
            bus.cout !== m_cout || bus.overflow !== m_ovf) begin
            failures++;
            $display("FAIL cycle t=%0t got rdy=%b bsy=%b dn=%b sum=%h co=%b ov=%b exp rdy=%b bsy=%b dn=%b sum=%h co=%b ov=%b",
                     $time, bus.ready, bus.busy, bus.done, bus.sum, bus.cout, bus.overflow,
                     phase == 0, phase != 0, m_done, m_sum, m_cout, m_ovf);
        end
    end

    task automatic wait_done(input string nm, input logic [W-1:0] es,
                             input logic ec, input logic eo);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.done && n < 20);
        checks++;
        if (n != W + 1 || bus.sum !== es || bus.cout !== ec || bus.overflow !== eo) begin
            failures++;
            $display("FAIL %s got lat=%0d sum=%h co=%b ov=%b exp lat=%0d sum=%h co=%b ov=%b",
                     nm, n, bus.sum, bus.cout, bus.overflow, W + 1, es, ec, eo);
        end
    endtask

    // called at posedge+1 with the block idle
    task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic [W-1:0] es,
                          input logic ec, input logic eo);
        bus.a     = a;
        bus.b     = b;
        bus.cin   = ci;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.cin   = 1'($urandom);
        wait_done(nm, es, ec, eo);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        #1;
        checks++;
        if (bus.sum !== 8'h00 || bus.cout !== 1'b0 || bus.overflow !== 1'b0 ||
            bus.done !== 1'b0 || bus.ready !== 1'b1 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset got sum=%h co=%b ov=%b dn=%b rdy=%b bsy=%b",
                     bus.sum, bus.cout, bus.overflow, bus.done, bus.ready, bus.busy);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("add_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        run_op("add_7f_cin", 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1);

        // start while busy is ignored
        bus.a     = 8'h11;
        bus.b     = 8'h22;
        bus.cin   = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.a     = 8'hFF;
        bus.b     = 8'hFF;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checks++;
        if (bus.ready !== 1'b0) begin
            failures++;
            $display("FAIL busy_ready got %b exp 0", bus.ready);
        end
        begin
            int n = 3;
            while (!bus.done && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
            checks++;
            if (n != W + 1 || bus.sum !== 8'h33) begin
                failures++;
                $display("FAIL ignore_start got lat=%0d sum=%h exp lat=%0d sum=33",
                         n, bus.sum, W + 1);
            end
        end
        repeat (3) @(posedge clk);
        #1;

        // reset mid-operation
        bus.a     = 8'h0F;
        bus.b     = 8'h01;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.sum !== 8'h00 || bus.done !== 1'b0 || bus.ready !== 1'b1 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got sum=%h dn=%b rdy=%b bsy=%b exp 00 0 1 0",
                     bus.sum, bus.done, bus.ready, bus.busy);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_op("after_reset", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

        // randomized traffic, including held start and occasional reset
        for (int i = 0; i < 800; i++) begin
            bus.start = ($urandom_range(0, 3) != 0);
            bus.a     = W'($urandom);
            bus.b     = W'($urandom);
            bus.cin   = 1'($urandom);
            rst       = ($urandom_range(0, 199) == 0);
            @(posedge clk);
            #1;
        end
        rst       = 1'b0;
        bus.start = 1'b0;
        repeat (W + 4) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial adder controller. One shared 1-bit full-adder cell adds two WIDTH-bit operands LSB-first over WIDTH cycles.
- The controller owns operand loading, carry sequencing, the bit counter, result assembly and a start/done handshake.
- Sits between a register-file/control block and the shared adder datapath, trading area for latency.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- Clk  input  1  rising-edge clock
- Rst  input  1  asynchronous, active-high reset
- Start  input  1  request to begin an addition; accepted only while Ready=1
- A  input  WIDTH  operand A, sampled on the accepting edge
- B  input  WIDTH  operand B, sampled on the accepting edge
- Cin  input  1  carry-in, sampled on the accepting edge
- Ready  output  1  high in IDLE; block can accept Start
- Busy  output  1  high in ADD and DONE
- Sum  output  WIDTH  registered result; holds last completed result
- Cout  output  1  registered carry-out of the MSB
- Overflow  output  1  registered two's-complement overflow flag
- Done  output  1  one-cycle pulse; results are valid and stable from this cycle on

Behaviour:
- Reset (async, Rst=1): state=IDLE; counter, operand shift registers and internal carry = 0; Sum=0, Cout=0, Overflow=0, Done=0. Ready=1, Busy=0 while Rst is held.
- States:
  - IDLE: Ready=1. Start=1 at an edge loads A, B into shift registers, carry<=Cin, counter<=0, state->ADD. Start=0 keeps IDLE.
  - ADD: one bit per cycle.
    - s = a0^b0^c; cnext = a0&b0 | c&(a0^b0).
    - s shifts into the MSB of the internal result shift register; operands shift right; carry<=cnext; counter++.
    - On the cycle where counter==WIDTH-1, also capture the carry into the MSB (c before update) for overflow, then state->DONE.
  - DONE: Sum<=result register; Cout<=final carry; Overflow<=carry-into-MSB ^ carry-out-of-MSB; Done=1 this cycle only; state->IDLE.
- Latency: accept at edge 0. ADD occupies edges 1..WIDTH. Sum/Cout/Overflow update and Done pulses in the cycle after edge WIDTH+1. Throughput is one op per WIDTH+2 cycles.
- Sum/Cout/Overflow change only on the DONE transition. They hold between operations and do not glitch during ADD.
- Start while Busy: ignored, no queuing, no error flag. Start held high across DONE->IDLE is accepted at the first IDLE edge.
- A, B, Cin changing after acceptance have no effect on the operation in flight.
- Reset mid-operation aborts immediately: all outputs return to reset values and the partial result is discarded.
- Arithmetic is modulo 2^WIDTH, with the carry reported in Cout. Counter width is $clog2(WIDTH). The counter never wraps past WIDTH-1 within an operation.
- Unused state encodings return to IDLE.

Decomposition:
- Shared package:
  - state enum (IDLE, ADD, DONE) as 2-bit localparams
  - default WIDTH constant
  - counter-width function
- Sub-module full_adder_bit: 1-bit combinational full adder built as two half-adder stages plus an OR. The controller instantiates it once.
- Everything else (FSM, counter, shift registers, result and flag registers) stays in serial_adder_ctrl.

Test Plan:
- WIDTH=8, after reset: Sum=0x00, Cout=0, Overflow=0, Done=0, Ready=1, Busy=0.
- A=0x5A, B=0x3C, Cin=0, Start pulse -> Done pulses exactly 9 cycles after the accepting edge; Sum=0x96, Cout=0, Overflow=1.
- A=0xFF, B=0x01, Cin=0 -> Sum=0x00, Cout=1, Overflow=0. Then A=0x80, B=0x80 -> Sum=0x00, Cout=1, Overflow=1.
- A=0x7F, B=0x00, Cin=1 -> Sum=0x80, Cout=0, Overflow=1. Carry-in must propagate through all 7 low bits.
- Start 0x11+0x22. On cycle 3 of ADD, assert Start with A=0xFF, B=0xFF -> ignored. Result is Sum=0x33, exactly one Done pulse, Ready low throughout ADD and DONE.
- Start 0x0F+0x01, assert Rst during ADD cycle 4 -> outputs at reset values immediately, no Done. After release, 0x01+0x01 -> Sum=0x02 after 9 cycles.
